// File: rtl/parking_occupancy_counter_pkg.sv
// Shared gate-FSM state encoding and sensor codes ({a,b}) for the parking occupancy counter.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    WAIT = 3'd7
  } gate_state_t;

  localparam logic [1:0] SENS_CLEAR = 2'b00;
  localparam logic [1:0] SENS_OUTER = 2'b10;
  localparam logic [1:0] SENS_BOTH  = 2'b11;
  localparam logic [1:0] SENS_INNER = 2'b01;

endpackage

// File: rtl/parking_occupancy_counter_bcd.sv
// Two-digit BCD up/down counter that saturates at 0 and MAX_COUNT.
module bcd_updown_counter #(
  parameter int MAX_COUNT = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       full,
  output logic       empty
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  assign full  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign empty = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (inc && !full) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec && !empty) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Gate-sensor sequence FSM recognising car entries/exits, driving a saturating BCD occupancy count.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int MAX_COUNT = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       full,
  output logic       empty,
  output logic       enter,
  output logic       exit
);

  gate_state_t state_q;
  logic        enter_q;
  logic        exit_q;
  logic [1:0]  sens;
  logic        inc;
  logic        dec;

  assign sens = {a, b};

  // Completion edges feed the counter directly so digits and pulse land on the same clock.
  assign inc = (state_q == EN3) && (sens == SENS_CLEAR);
  assign dec = (state_q == EX3) && (sens == SENS_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      enter_q <= inc;
      exit_q  <= dec;
      case (state_q)
        IDLE: case (sens)
          SENS_OUTER: state_q <= EN1;
          SENS_INNER: state_q <= EX1;
          SENS_BOTH:  state_q <= WAIT;
          default:    state_q <= IDLE;
        endcase
        EN1: case (sens)
          SENS_BOTH:  state_q <= EN2;
          SENS_CLEAR: state_q <= IDLE;
          SENS_INNER: state_q <= WAIT;
          default:    state_q <= EN1;
        endcase
        EN2: case (sens)
          SENS_INNER: state_q <= EN3;
          SENS_OUTER: state_q <= EN1;
          SENS_CLEAR: state_q <= WAIT;
          default:    state_q <= EN2;
        endcase
        EN3: case (sens)
          SENS_CLEAR: state_q <= IDLE;
          SENS_BOTH:  state_q <= EN2;
          SENS_OUTER: state_q <= WAIT;
          default:    state_q <= EN3;
        endcase
        EX1: case (sens)
          SENS_BOTH:  state_q <= EX2;
          SENS_CLEAR: state_q <= IDLE;
          SENS_OUTER: state_q <= WAIT;
          default:    state_q <= EX1;
        endcase
        EX2: case (sens)
          SENS_OUTER: state_q <= EX3;
          SENS_INNER: state_q <= EX1;
          SENS_CLEAR: state_q <= WAIT;
          default:    state_q <= EX2;
        endcase
        EX3: case (sens)
          SENS_CLEAR: state_q <= IDLE;
          SENS_BOTH:  state_q <= EX2;
          SENS_INNER: state_q <= WAIT;
          default:    state_q <= EX3;
        endcase
        default: state_q <= (sens == SENS_CLEAR) ? IDLE : WAIT;
      endcase
    end
  end

  bcd_updown_counter #(
    .MAX_COUNT(MAX_COUNT)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .ones  (ones),
    .tens  (tens),
    .full  (full),
    .empty (empty)
  );

  assign enter = enter_q;
  assign exit  = exit_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for parking_occupancy_counter with hand-computed expected values (MAX_COUNT=25).
module tb_parking_occupancy_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       full;
  logic       empty;
  logic       enter;
  logic       exit;

  int checks = 0;
  int errors = 0;

  parking_occupancy_counter #(.MAX_COUNT(25)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .ones  (ones),
    .tens  (tens),
    .full  (full),
    .empty (empty),
    .enter (enter),
    .exit  (exit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a sensor code and wait n cycles; always entered and left at a negedge.
  task automatic hold(input logic [1:0] code, input int n);
    {a, b} = code;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_count(input string tag, input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_digits"}, {tens, ones}, {t, o});
  endtask

  task automatic do_entry(input string tag, input logic exp_pulse);
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b01, 2); hold(2'b00, 1);
    chk({tag, "_enter"}, {7'd0, enter}, {7'd0, exp_pulse});
    chk({tag, "_noexit"}, {7'd0, exit}, 8'd0);
    hold(2'b00, 1);
    chk({tag, "_enter_end"}, {7'd0, enter}, 8'd0);
  endtask

  task automatic do_exit(input string tag);
    hold(2'b01, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 1);
    chk({tag, "_exit"}, {7'd0, exit}, 8'd1);
    chk({tag, "_noenter"}, {7'd0, enter}, 8'd0);
    hold(2'b00, 1);
    chk({tag, "_exit_end"}, {7'd0, exit}, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {a, b} = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic quiet_entries(input int n);
    for (int i = 0; i < n; i++) begin
      hold(2'b10, 1); hold(2'b11, 1); hold(2'b01, 1); hold(2'b00, 2);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_count("reset", 4'd0, 4'd0);
    chk("reset_flags", {4'd0, empty, full, enter, exit}, 8'b0000_1000);
    hold(2'b00, 5);
    chk("idle_hold", {tens, ones, empty, full, enter, exit}, {8'h00, 4'b1000});

    do_entry("entry1", 1'b1);
    chk_count("entry1", 4'd0, 4'd1);
    chk("entry1_empty", {7'd0, empty}, 8'd0);
    for (int i = 2; i <= 10; i++) do_entry("entryN", 1'b1);
    chk_count("entry10", 4'd1, 4'd0);

    quiet_entries(15);
    chk_count("at25", 4'd2, 4'd5);
    chk("at25_full", {7'd0, full}, 8'd1);
    do_entry("sat", 1'b1);
    chk_count("sat", 4'd2, 4'd5);
    chk("sat_full", {7'd0, full}, 8'd1);
    do_exit("from25");
    chk_count("from25", 4'd2, 4'd4);
    chk("from25_full", {7'd0, full}, 8'd0);

    do_reset();
    do_exit("at0");
    chk_count("at0", 4'd0, 4'd0);
    chk("at0_empty", {7'd0, empty}, 8'd1);
    quiet_entries(10);
    chk_count("at10", 4'd1, 4'd0);
    do_exit("from10");
    chk_count("from10", 4'd0, 4'd9);

    do_reset();
    quiet_entries(3);
    chk_count("at3", 4'd0, 4'd3);
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 1);
    chk("backout", {tens, ones, enter, exit}, {8'h03, 2'b00});
    hold(2'b00, 1); hold(2'b11, 2); hold(2'b00, 1);
    chk("wait11", {tens, ones, enter, exit}, {8'h03, 2'b00});
    hold(2'b00, 1); hold(2'b10, 2); hold(2'b01, 2); hold(2'b00, 1);
    chk("wait_jump", {tens, ones, enter, exit}, {8'h03, 2'b00});
    hold(2'b00, 1);
    do_entry("after_wait", 1'b1);
    chk_count("after_wait", 4'd0, 4'd4);

    do_reset();
    quiet_entries(7);
    chk_count("at7", 4'd0, 4'd7);
    hold(2'b10, 2); hold(2'b11, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_count("midreset", 4'd0, 4'd0);
    hold(2'b01, 2); hold(2'b00, 1);
    chk("midreset_seq", {tens, ones, enter, exit}, {8'h00, 2'b00});
    hold(2'b00, 1);

    quiet_entries(1);
    hold(2'b10, 1); hold(2'b11, 1); hold(2'b01, 1);
    {a, b} = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_on_complete", {tens, ones, enter, exit}, {8'h00, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
- Upstream stage for the per-digit 7-segment decoders in the parking-lot design.
- Watches two gate photo-sensors (outer a, inner b) and recognises complete car-enter and car-exit sequences.
- Keeps a saturating occupancy count in two BCD digits; each digit drives one hex decoder (digit values always 0-9).
- Also flags full/empty and pulses one cycle per recognised event.

Parameters:
MAX_COUNT, 25, lot capacity; legal range 1..99; count never exceeds it

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
a  input  1  outer sensor, 1 = beam blocked; already synchronised to clk
b  input  1  inner sensor, 1 = beam blocked; already synchronised to clk
ones  output  4  BCD ones digit of occupancy, 0-9
tens  output  4  BCD tens digit of occupancy, 0-9
full  output  1  high while count == MAX_COUNT
empty  output  1  high while count == 0
enter  output  1  one-cycle pulse on completed entry
exit  output  1  one-cycle pulse on completed exit

Behaviour:
- Reset (sampled high at a rising edge): state=IDLE, ones=0, tens=0, enter=0, exit=0; hence empty=1, full=0. Reset overrides all sensor activity, including mid-sequence and on a completing cycle: no pulse, count cleared.
- Sensor code is {a,b}. FSM states: IDLE, EN1 (10), EN2 (11), EN3 (01), EX1 (01), EX2 (11), EX3 (10), WAIT.
- IDLE: 10 -> EN1; 01 -> EX1; 11 -> WAIT; 00 -> stay.
- EN1: 11 -> EN2; 00 -> IDLE (aborted, no count); 01 -> WAIT; 10 -> stay.
- EN2: 01 -> EN3; 10 -> EN1 (backing out); 00 -> WAIT; 11 -> stay.
- EN3: 00 -> IDLE with entry completion; 11 -> EN2; 10 -> WAIT; 01 -> stay.
- EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped; EX3 with 00 -> IDLE with exit completion.
- WAIT (illegal jump seen): stay until 00, then -> IDLE. No count, no pulse.
- Entry completion edge:
  - enter <= 1 for exactly one cycle.
  - If count < MAX_COUNT, count increments: ones==9 -> ones=0, tens+1; else ones+1.
  - If count == MAX_COUNT: enter still pulses, count unchanged (saturate).
- Exit completion edge:
  - exit <= 1 for exactly one cycle.
  - If count > 0, count decrements: ones==0 -> ones=9, tens-1; else ones-1.
  - If count == 0: exit still pulses, count unchanged.
- Latency: pulse and new digits both visible in the cycle after the completing edge. full/empty are combinational from the registered digits and track the count in that same cycle.
- enter and exit are never high together; only one sequence can be in progress.
- Holding 00 in IDLE for any duration changes nothing.
- Digits never leave BCD range 0-9. Tens never wraps: saturation prevents it.

Decomposition:
- Package parking_pkg:
  - gate_state_t enum (IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT)
  - localparams SENS_CLEAR=2'b00, SENS_OUTER=2'b10, SENS_BOTH=2'b11, SENS_INNER=2'b01
- Sub-module bcd_updown_counter, #(MAX_COUNT):
  - ports: clk, reset, inc, dec, ones, tens, full, empty
  - implements the saturating two-digit BCD arithmetic
  - parent FSM drives inc/dec from the completion edges

Test Plan:
1. Reset held 2 cycles, then released -> ones=0, tens=0, empty=1, full=0, enter=exit=0.
2. Entry {a,b}=10,11,01,00, each held 2 cycles -> enter high for exactly 1 cycle; ones=1, tens=0, empty=0. Repeat 10 times from 0 -> ones=0, tens=1 on the 10th.
3. Count at 25 (MAX_COUNT=25), one more entry -> enter pulses, digits stay 2/5, full stays 1. Then one exit -> exit pulses, digits 2/4, full=0.
4. Count 0, exit sequence 01,11,10,00 -> exit pulses, digits stay 0/0, empty=1. From count 10, one exit -> tens=0, ones=9.
5. Aborted and illegal sequences from count 3:
   - 10,11,10,00 (back out) -> no pulse, count 3.
   - 00->11->00 -> WAIT then IDLE, no pulse, count 3.
   - 10,01,00 -> WAIT, no pulse, count 3.
6. Reset mid-sequence: count 7, sensors at 11 in EN2, reset for 1 cycle, then 01,00 -> count 0/0; no enter pulse, because the FSM restarts in IDLE and 01 is treated as the start of an exit.
